// File: rtl/cl_axil_regfile.sv
// AXI4-Lite slave register file for the CL OCL BAR0 path.
// NUM_REGS 32-bit registers at BASE_ADDR, each RW or RO. Supports byte-strobe
// writes and optional byte-swapped read-back. Bad accesses get SLVERR.
// Read and write channels are independent, with one transaction in flight each.
module cl_axil_regfile #(
  parameter int unsigned NUM_REGS     = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0500,
  parameter logic [63:0] RO_MASK      = 64'h0,
  parameter logic [63:0] SWAP_MASK    = 64'h1,
  parameter logic [31:0] RESET_VAL    = 32'h0,
  parameter logic [31:0] UNIMPL_VALUE = 32'hDEAF_DEAF,
  parameter bit          ERR_RESP_EN  = 1'b1
) (
  input  logic                     clk_main_a0,
  input  logic                     rst_main,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              awaddr,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [1:0]               bresp,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [31:0]              araddr,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic [NUM_REGS*32-1:0]   reg_q,
  input  logic [NUM_REGS*32-1:0]   ro_in,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int unsigned          IW   = $clog2(NUM_REGS);
  localparam logic [31:0]          SPAN = 32'(4 * NUM_REGS);
  localparam logic [NUM_REGS-1:0]  RO   = RO_MASK[NUM_REGS-1:0];
  localparam logic [NUM_REGS-1:0]  SW   = SWAP_MASK[NUM_REGS-1:0];
  localparam logic [1:0]           BAD  = ERR_RESP_EN ? 2'b10 : 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LOOKUP, R_RESP} r_state_t;

  w_state_t    w_state;
  r_state_t    r_state;

  logic [31:0] regs   [NUM_REGS];
  logic [31:0] ro_arr [NUM_REGS];

  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic [31:0] ar_addr_q;

  // RO slices of reg_q read as zero; ro_in is repacked for indexed lookup.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_map
    assign reg_q[32*gi +: 32] = RO[gi] ? '0 : regs[gi];
    assign ro_arr[gi]         = ro_in[32*gi +: 32];
  end

  logic          aw_hs, w_hs, commit;
  logic [31:0]   c_addr, c_data, c_off;
  logic [3:0]    c_strb;
  logic          c_valid, c_ok;
  logic [IW-1:0] c_idx;

  // Write-side commit decode: pick latched or live address/data by state.
  always_comb begin
    aw_hs   = awvalid & awready;
    w_hs    = wvalid & wready;
    c_addr  = (w_state == W_HAVE_ADDR) ? aw_addr_q : awaddr;
    c_data  = (w_state == W_HAVE_DATA) ? w_data_q  : wdata;
    c_strb  = (w_state == W_HAVE_DATA) ? w_strb_q  : wstrb;
    c_off   = c_addr - BASE_ADDR;
    c_valid = (c_addr[1:0] == 2'b00) && (c_addr >= BASE_ADDR) && (c_off < SPAN);
    c_idx   = c_off[IW+1:2];
    c_ok    = c_valid && !RO[c_idx];
    case (w_state)
      W_IDLE:      commit = aw_hs & w_hs;
      W_HAVE_ADDR: commit = w_hs;
      W_HAVE_DATA: commit = aw_hs;
      default:     commit = 1'b0;
    endcase
  end

  logic [31:0]   r_off, r_word, r_data_nx;
  logic [1:0]    r_resp_nx;
  logic          r_valid;
  logic [IW-1:0] r_idx;

  // Read lookup from the latched address, using pre-edge register contents.
  always_comb begin
    r_off     = ar_addr_q - BASE_ADDR;
    r_valid   = (ar_addr_q[1:0] == 2'b00) && (ar_addr_q >= BASE_ADDR) && (r_off < SPAN);
    r_idx     = r_off[IW+1:2];
    r_word    = '0;
    r_data_nx = UNIMPL_VALUE;
    r_resp_nx = BAD;
    if (r_valid) begin
      r_word    = RO[r_idx] ? ro_arr[r_idx] : regs[r_idx];
      r_data_nx = SW[r_idx] ? {r_word[7:0], r_word[15:8], r_word[23:16], r_word[31:24]}
                            : r_word;
      r_resp_nx = 2'b00;
    end
  end

  // Write FSM, register storage and commit strobes.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      w_state   <= W_IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= '0;
      wr_pulse  <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        if (c_ok) begin
          for (int unsigned k = 0; k < 4; k++)
            if (c_strb[k]) regs[c_idx][8*k +: 8] <= c_data[8*k +: 8];
          wr_pulse[c_idx] <= 1'b1;
        end
        bresp   <= c_ok ? 2'b00 : BAD;
        bvalid  <= 1'b1;
        awready <= 1'b0;
        wready  <= 1'b0;
        w_state <= W_RESP;
      end else begin
        case (w_state)
          W_IDLE: begin
            awready <= 1'b1;
            wready  <= 1'b1;
            if (aw_hs) begin
              aw_addr_q <= awaddr;
              awready   <= 1'b0;
              w_state   <= W_HAVE_ADDR;
            end else if (w_hs) begin
              w_data_q <= wdata;
              w_strb_q <= wstrb;
              wready   <= 1'b0;
              w_state  <= W_HAVE_DATA;
            end
          end
          W_RESP: begin
            if (bready) begin
              bvalid  <= 1'b0;
              bresp   <= '0;
              awready <= 1'b1;
              wready  <= 1'b1;
              w_state <= W_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read FSM: accept address, one lookup cycle, then hold the response.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      r_state   <= R_IDLE;
      arready   <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= '0;
      ar_addr_q <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            ar_addr_q <= araddr;
            arready   <= 1'b0;
            r_state   <= R_LOOKUP;
          end
        end
        R_LOOKUP: begin
          rdata   <= r_data_nx;
          rresp   <= r_resp_nx;
          rvalid  <= 1'b1;
          r_state <= R_RESP;
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
